// File: rtl/lab2_proc_imm_encoder_if.sv
// Request/response bus of the immediate encoder: a val/rdy request carrying
// type, immediate and template, and a val/rdy response carrying the packed instruction.
interface lab2_proc_imm_encoder_if;
  logic        req_val;
  logic        req_rdy;
  logic [2:0]  req_type;
  logic [31:0] req_imm;
  logic [31:0] req_inst;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_inst;
  logic        resp_err;

  modport master (
    output req_val, req_type, req_imm, req_inst, resp_rdy,
    input  req_rdy, resp_val, resp_inst, resp_err
  );

  modport slave (
    input  req_val, req_type, req_imm, req_inst, resp_rdy,
    output req_rdy, resp_val, resp_inst, resp_err
  );
endinterface

// File: rtl/lab2_proc_imm_encoder.sv
// Packs an immediate into the RISC-V I/S/B/U/J instruction fields of a template,
// flags unencodable immediates, and buffers results in a 2-entry output queue.
module lab2_proc_imm_encoder #(
  parameter int p_err_cnt_nbits = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  lab2_proc_imm_encoder_if.slave     bus,
  output logic [p_err_cnt_nbits-1:0] err_count
);

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  logic        sext_ok_11;
  logic        sext_ok_12;
  logic        sext_ok_20;
  logic        enc_ok;
  logic [31:0] cand_inst;
  logic [31:0] enc_inst;

  // Upper bits must be a pure sign extension for the immediate to fit the field.
  assign sext_ok_11 = (&bus.req_imm[31:11]) || !(|bus.req_imm[31:11]);
  assign sext_ok_12 = (&bus.req_imm[31:12]) || !(|bus.req_imm[31:12]);
  assign sext_ok_20 = (&bus.req_imm[31:20]) || !(|bus.req_imm[31:20]);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    cand_inst = bus.req_inst;
    enc_ok    = 1'b0;
    case (imm_type_e'(bus.req_type))
      IMM_I: begin
        enc_ok            = sext_ok_11;
        cand_inst[31:20]  = bus.req_imm[11:0];
      end
      IMM_S: begin
        enc_ok            = sext_ok_11;
        cand_inst[31:25]  = bus.req_imm[11:5];
        cand_inst[11:7]   = bus.req_imm[4:0];
      end
      IMM_B: begin
        enc_ok            = sext_ok_12 && !bus.req_imm[0];
        cand_inst[31]     = bus.req_imm[12];
        cand_inst[7]      = bus.req_imm[11];
        cand_inst[30:25]  = bus.req_imm[10:5];
        cand_inst[11:8]   = bus.req_imm[4:1];
      end
      IMM_U: begin
        enc_ok            = (bus.req_imm[11:0] == 12'd0);
        cand_inst[31:12]  = bus.req_imm[31:12];
      end
      IMM_J: begin
        enc_ok            = sext_ok_20 && !bus.req_imm[0];
        cand_inst[31]     = bus.req_imm[20];
        cand_inst[19:12]  = bus.req_imm[19:12];
        cand_inst[20]     = bus.req_imm[11];
        cand_inst[30:21]  = bus.req_imm[10:1];
      end
      default: begin
        enc_ok            = 1'b0;
      end
    endcase
    enc_inst = enc_ok ? cand_inst : bus.req_inst;
  end

  logic [1:0]                 count_q;
  logic                       head_q;
  logic                       tail_q;
  logic [31:0]                entry_inst_q [0:1];
  logic                       entry_err_q  [0:1];
  logic [31:0]                last_inst_q;
  logic                       last_err_q;
  logic [p_err_cnt_nbits-1:0] err_count_q;
  logic                       enq;
  logic                       deq;

  assign bus.req_rdy  = (count_q != 2'd2);
  assign bus.resp_val = (count_q != 2'd0);
  assign enq          = bus.req_val  && bus.req_rdy;
  assign deq          = bus.resp_val && bus.resp_rdy;

  // An empty queue keeps showing the last dequeued entry rather than stale storage.
  assign bus.resp_inst = bus.resp_val ? entry_inst_q[head_q] : last_inst_q;
  assign bus.resp_err  = bus.resp_val ? entry_err_q[head_q]  : last_err_q;
  assign err_count     = err_count_q;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the two queue entries are reset along with the control state, so the
    // response fields are defined zeros straight out of reset.
    if (reset) begin
      count_q         <= 2'd0;
      head_q          <= 1'b0;
      tail_q          <= 1'b0;
      entry_inst_q[0] <= 32'd0;
      entry_inst_q[1] <= 32'd0;
      entry_err_q[0]  <= 1'b0;
      entry_err_q[1]  <= 1'b0;
      last_inst_q     <= 32'd0;
      last_err_q      <= 1'b0;
      err_count_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // pre-edge values regardless of statement order.
      if (enq) begin
        entry_inst_q[tail_q] <= enc_inst;
        entry_err_q[tail_q]  <= !enc_ok;
        tail_q               <= !tail_q;
        if (!enc_ok && (err_count_q != {p_err_cnt_nbits{1'b1}})) begin
          err_count_q <= err_count_q + 1'b1;
        end
      end
      if (deq) begin
        last_inst_q <= entry_inst_q[head_q];
        last_err_q  <= entry_err_q[head_q];
        head_q      <= !head_q;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lab2_proc_imm_encoder.sv
// Bench for lab2_proc_imm_encoder: range-based golden encoder plus queue scoreboard,
// directed test-plan vectors, backpressure, random streaming, saturation and reset.
module tb_lab2_proc_imm_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] err_count;

  lab2_proc_imm_encoder_if bus ();

  lab2_proc_imm_encoder #(.p_err_cnt_nbits(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Golden encoder: legality from signed ranges, packing by masks and shifts.
  function automatic void model_encode(input logic [2:0] t, input logic [31:0] imm,
                                       input logic [31:0] tmpl,
                                       output logic [31:0] inst, output logic err);
    int          s = $signed(imm);
    bit          ok;
    logic [31:0] v;
    case (t)
      3'd0: begin
        ok = (s >= -2048) && (s <= 2047);
        v  = (tmpl & 32'h000FFFFF) | (imm << 20);
      end
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        v  = (tmpl & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      end
      3'd2: begin
        ok = (s >= -4096) && (s <= 4095) && (imm % 2 == 0);
        v  = (tmpl & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31) |
             (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8) |
             (((imm >> 11) & 32'h1) << 7);
      end
      3'd3: begin
        ok = (imm % 4096 == 0);
        v  = (tmpl & 32'h00000FFF) | (imm & 32'hFFFFF000);
      end
      3'd4: begin
        ok = (s >= -1048576) && (s <= 1048575) && (imm % 2 == 0);
        v  = (tmpl & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31) |
             (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20) |
             (imm & 32'h000FF000);
      end
      default: begin
        ok = 1'b0;
        v  = tmpl;
      end
    endcase
    err  = !ok;
    inst = ok ? v : tmpl;
  endfunction

  // The processor's immediate generator, used for the round-trip check.
  function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] t);
    case (t)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {i[31:12], 12'd0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] rand_imm();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 4))
      0:       return r;
      1:       return {{20{r[11]}}, r[11:0]};
      2:       return {{19{r[12]}}, r[12:1], 1'b0};
      3:       return {{11{r[20]}}, r[20:1], 1'b0};
      default: return {r[31:12], 12'd0};
    endcase
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [2:0]  typ;
    logic [31:0] imm;
  } exp_t;

  exp_t        mq[$];
  int          m_errs      = 0;
  logic [31:0] m_last_inst = 32'd0;
  logic        m_last_err  = 1'b0;

  // Scoreboard update on each clock edge, from pre-edge input values.
  always @(posedge clk or posedge reset) begin : model
    bit   enq;
    bit   deq;
    exp_t e;
    if (reset) begin
      mq.delete();
      m_errs      = 0;
      m_last_inst = 32'd0;
      m_last_err  = 1'b0;
    end else begin
      deq = (mq.size() != 0) && (bus.resp_rdy === 1'b1);
      enq = (bus.req_val === 1'b1) && (mq.size() != 2);
      if (deq) begin
        e           = mq.pop_front();
        m_last_inst = e.inst;
        m_last_err  = e.err;
        if (!e.err) check("roundtrip", decode(bus.resp_inst, e.typ), e.imm);
      end
      if (enq) begin
        e.typ = bus.req_type;
        e.imm = bus.req_imm;
        model_encode(bus.req_type, bus.req_imm, bus.req_inst, e.inst, e.err);
        mq.push_back(e);
        if (e.err && m_errs < 255) m_errs++;
      end
    end
  end

  // Cycle-by-cycle compare, on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("req_rdy",   32'(bus.req_rdy),  32'(mq.size() != 2));
      check("resp_val",  32'(bus.resp_val), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("resp_inst", bus.resp_inst,      mq[0].inst);
        check("resp_err",  32'(bus.resp_err),  32'(mq[0].err));
      end else begin
        check("hold_inst", bus.resp_inst,      m_last_inst);
        check("hold_err",  32'(bus.resp_err),  32'(m_last_err));
      end
      check("err_count", 32'(err_count), 32'(m_errs));
    end
  end

  task automatic directed(input string name, input logic [2:0] t, input logic [31:0] imm,
                          input logic [31:0] tmpl, input logic [31:0] exp_inst,
                          input logic exp_err);
    @(negedge clk);
    bus.req_val  = 1'b1;
    bus.req_type = t;
    bus.req_imm  = imm;
    bus.req_inst = tmpl;
    bus.resp_rdy = 1'b0;
    @(negedge clk);
    bus.req_val = 1'b0;
    check({name, "_inst"}, bus.resp_inst, exp_inst);
    check({name, "_err"},  32'(bus.resp_err), 32'(exp_err));
    bus.resp_rdy = 1'b1;
    @(negedge clk);
    bus.resp_rdy = 1'b0;
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] tmpl);
    bus.req_val  = 1'b1;
    bus.req_type = t;
    bus.req_imm  = imm;
    bus.req_inst = tmpl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] pin_inst;
    logic        pin_err;
    int          accepted;
    bit          acc;

    bus.req_val  = 1'b0;
    bus.req_type = 3'd0;
    bus.req_imm  = 32'd0;
    bus.req_inst = 32'd0;
    bus.resp_rdy = 1'b0;

    // Pin the golden encoder to hand-computed values.
    model_encode(3'd2, 32'hFFFFFFFC, 32'h00000063, pin_inst, pin_err);
    check("model_B", pin_inst, 32'hFE000EE3);
    model_encode(3'd4, 32'h00000008, 32'h0000006F, pin_inst, pin_err);
    check("model_J", pin_inst, 32'h0080006F);
    model_encode(3'd1, 32'h00000804, 32'h00002023, pin_inst, pin_err);
    check("model_S_err", 32'(pin_err), 32'd1);

    repeat (2) @(negedge clk);
    check("rst_resp_val",  32'(bus.resp_val), 32'd0);
    check("rst_req_rdy",   32'(bus.req_rdy),  32'd1);
    check("rst_resp_inst", bus.resp_inst,     32'd0);
    check("rst_resp_err",  32'(bus.resp_err), 32'd0);
    check("rst_err_count", 32'(err_count),    32'd0);
    reset = 1'b0;

    directed("I_neg1",  3'd0, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0);
    directed("S_range", 3'd1, 32'h00000804, 32'h00002023, 32'h00002023, 1'b1);
    check("err_count_1", 32'(err_count), 32'd1);
    directed("B_neg4",  3'd2, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0);
    directed("J_8",     3'd4, 32'h00000008, 32'h0000006F, 32'h0080006F, 1'b0);
    directed("B_6",     3'd2, 32'h00000006, 32'h00000063, 32'h00000363, 1'b0);
    directed("B_odd",   3'd2, 32'h00000005, 32'h00000063, 32'h00000063, 1'b1);
    directed("U_ok",    3'd3, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0);
    directed("U_low",   3'd3, 32'h12345001, 32'h00000037, 32'h00000037, 1'b1);
    directed("T6",      3'd6, 32'h00000000, 32'h00000013, 32'h00000013, 1'b1);

    // Backpressure: three back-to-back requests with the response side stalled.
    @(negedge clk);
    bus.resp_rdy = 1'b0;
    drive(3'd0, 32'd1, 32'h00000013);
    @(negedge clk);
    drive(3'd0, 32'd2, 32'h00000013);
    @(negedge clk);
    drive(3'd0, 32'd3, 32'h00000013);
    @(negedge clk);
    check("bp_req_rdy", 32'(bus.req_rdy), 32'd0);
    check("bp_head",    bus.resp_inst,    32'h00100013);
    bus.resp_rdy = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(posedge clk);
      acc = bus.req_val && bus.req_rdy;
      @(negedge clk);
    end
    bus.req_val = 1'b0;
    check("bp_third_accepted", 32'(acc), 32'd1);
    repeat (4) @(negedge clk);

    // Random streaming with random response backpressure.
    accepted = 0;
    for (int cyc = 0; cyc < 3000 && accepted < 100; cyc++) begin
      @(negedge clk);
      drive(($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7)),
            rand_imm(), $urandom);
      bus.req_val  = ($urandom_range(0, 3) != 0);
      bus.resp_rdy = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      if (bus.req_val && bus.req_rdy) accepted++;
    end
    @(negedge clk);
    bus.req_val  = 1'b0;
    bus.resp_rdy = 1'b1;
    check("stream_accepted", 32'(accepted), 32'd100);
    repeat (4) @(negedge clk);

    // Error counter saturation.
    accepted = 0;
    drive(3'd7, 32'd0, 32'h00000013);
    for (int cyc = 0; cyc < 1000 && accepted < 300; cyc++) begin
      @(posedge clk);
      if (bus.req_val && bus.req_rdy) accepted++;
      @(negedge clk);
    end
    bus.req_val = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_accepted",  32'(accepted),  32'd300);
    check("sat_err_count", 32'(err_count), 32'd255);

    // Reset with two entries queued.
    bus.resp_rdy = 1'b0;
    drive(3'd0, 32'd5, 32'h00000013);
    repeat (2) @(negedge clk);
    bus.req_val = 1'b0;
    check("pre_rst_req_rdy", 32'(bus.req_rdy), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_resp_val",  32'(bus.resp_val), 32'd0);
    check("mid_rst_err_count", 32'(err_count),    32'd0);
    check("mid_rst_req_rdy",   32'(bus.req_rdy),  32'd1);
    check("mid_rst_resp_inst", bus.resp_inst,     32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.resp_rdy = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lab2_proc_imm_encoder.md
# lab2_proc_imm_encoder

Inverse of the processor's immediate generator. Accepts a 32-bit immediate, an immediate type, and an instruction template, and packs the immediate into the RISC-V instruction fields for that type. Flags immediates that the type cannot represent. Used by the test-harness instruction assembler and self-modifying-code tests, between a val/rdy source and instruction memory writes. A 2-entry output queue decouples `req_rdy` from `resp_rdy`.

## Interface
- `p_err_cnt_nbits`, default 8: width of the saturating error counter.
- `clk` input 1: clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_val` input 1: request valid.
- `req_rdy` output 1: request ready.
- `req_type` input 3: 0=I, 1=S, 2=B, 3=U, 4=J, 5–7 illegal.
- `req_imm` input 32: full sign-extended immediate value (byte offset for B/J).
- `req_inst` input 32: instruction template. Non-immediate bits are copied verbatim.
- `resp_val` output 1: response valid.
- `resp_rdy` input 1: response ready.
- `resp_inst` output 32: encoded instruction.
- `resp_err` output 1: immediate not encodable; `resp_inst` equals the template unchanged.
- `err_count` output `p_err_cnt_nbits`: number of accepted requests with error, saturating.

## Operation
- Encoding is combinational at enqueue. Only the type's immediate bit positions are overwritten from `req_imm`; all other bits come from `req_inst`.
  - I: legal if `imm[31:11]` all equal. Mapping: `inst[31:20]=imm[11:0]`.
  - S: same range as I. Mapping: `inst[31:25]=imm[11:5]`, `inst[11:7]=imm[4:0]`.
  - B: legal if `imm[31:12]` all equal and `imm[0]==0`. Mapping: `inst[31]=imm[12]`, `inst[7]=imm[11]`, `inst[30:25]=imm[10:5]`, `inst[11:8]=imm[4:1]`.
  - U: legal if `imm[11:0]==0`. Mapping: `inst[31:12]=imm[31:12]`.
  - J: legal if `imm[31:20]` all equal and `imm[0]==0`. Mapping: `inst[31]=imm[20]`, `inst[19:12]=imm[19:12]`, `inst[20]=imm[11]`, `inst[30:21]=imm[10:1]`.
  - Types 5–7: always error.
- On error, the stored inst is `req_inst` unmodified and the stored err bit is 1.
- Round-trip requirement: for any legal request, feeding `resp_inst` and the same type through the immediate generator returns `req_imm`. U type zero-fills the low 12 bits.
- Queue: 2 entries, FIFO order, occupancy counter 0..2, one-bit enq and deq pointers.
  - enq = `req_val && req_rdy`.
  - deq = `resp_val && resp_rdy`.
  - `req_rdy = (count != 2)`. It depends only on registered state and never on `resp_rdy` or `req_val`.
  - `resp_val = (count != 0)`. `resp_inst` and `resp_err` come from the head entry. When count is 0 they hold their last value, which is 0 after reset.
- Simultaneous enq and deq:
  - count 1: count stays 1, the head advances, and the new entry is written.
  - count 2: enq is impossible.
  - count 0: no bypass; the new entry appears next cycle.
- `err_count` increments on enq of an erroring request. It saturates at 2^p−1 and never wraps.

## Timing
- Reset, asynchronous:
  - count=0, pointers=0, entries cleared to 0, `err_count`=0.
  - `resp_val`=0, `req_rdy`=1, `resp_inst`=0, `resp_err`=0.
- Latency: a request accepted in cycle N is visible on the response outputs in cycle N+1 if the queue was empty.
- Throughput: 1 request/cycle with `resp_rdy` held high.
- Backpressure: with `resp_rdy`=0, exactly 2 requests are accepted, then `req_rdy`=0 from the cycle after the second enq.
- The response stays stable while `resp_val && !resp_rdy`.
- Reset asserted mid-operation drops all queued entries immediately. No response is produced for them.

## Test plan
- I/S encoding:
  - type 0, imm 0xFFFFFFFF, template 0x00000013 -> 0xFFF00013, err 0.
  - type 1, imm 0x00000804, template 0x00002023 -> err 1, inst 0x00002023, `err_count` 1.
- B/J encoding:
  - type 2, imm 0xFFFFFFFC, template 0x00000063 -> 0xFE000EE3.
  - type 4, imm 8, template 0x0000006F -> 0x0080006F.
  - type 2, imm 6 -> err 0 with inst 0x00000363; type 2, imm 5 -> err 1.
- U and illegal types:
  - type 3, imm 0x12345000, template 0x00000037 -> 0x12345037.
  - type 3, imm 0x12345001 -> err 1.
  - type 6 -> err 1, inst unchanged.
- Backpressure: `resp_rdy`=0, drive 3 back-to-back requests -> 2 accepted, `req_rdy`=0. Raise `resp_rdy` -> the two drain in order, then the third is accepted. No loss, no duplication.
- Streaming: 100 random requests with random `resp_rdy` -> outputs match a golden encoder in order, and decoding each legal output returns the original imm.
- Saturation and reset:
  - 300 erroring requests -> `err_count` stops at 255.
  - Assert reset with 2 entries queued -> same cycle `resp_val`=0, `err_count`=0, `req_rdy`=1.
